// File: rtl/snap_capture_pkg.sv
// -----------------------------------------------------------------------------
// snap_capture_pkg
// Shared definitions for the snapshot capture controller.
//   state_t      : controller state encoding
//   *_BIT/*_LSB  : field positions inside the 32-bit software control word
//   WRAP_BIT     : position of the wrapped flag in the readback status word
// -----------------------------------------------------------------------------
package snap_capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Control word fields
    localparam int ARM_BIT      = 0;
    localparam int TRIG_EN_BIT  = 1;
    localparam int VALID_EN_BIT = 2;
    localparam int CIRC_BIT     = 3;
    localparam int STOP_BIT     = 4;
    localparam int DLY_LSB      = 16;

    // Status word fields
    localparam int WRAP_BIT     = 31;

endpackage

// File: rtl/snap_edge_det.sv
// -----------------------------------------------------------------------------
// snap_edge_det
// Registered rising-edge detector. o_rise is high in the cycle where i_d is
// high and was low on the previous clock edge.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (history cleared to 0)
//   i_d    : level input, synchronous to i_clk
//   o_rise : rising-edge indication (combinational from i_d and history)
// -----------------------------------------------------------------------------
module snap_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_d_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/snap_capture_ctrl.sv
// -----------------------------------------------------------------------------
// snap_capture_ctrl
// Sequences one snapshot BRAM capture from a software control word:
// arm (rising edge) -> wait for trigger -> optional post-trigger delay ->
// write address/enable into the snap BRAM -> report done/status.
//
// Optional build macro: SNAP_CAPTURE_TS_EN adds a free-running cycle counter
// and the trig_ts output, latched when the trigger is accepted.
//
// Ports:
//   user_clk   : single clock for all logic
//   user_rst   : asynchronous active-high reset
//   ctrl_word  : [0] arm, [1] trig_en, [2] valid_en, [3] circ, [4] stop,
//                [31:16] post-trigger delay
//   trig       : trigger level, sampled every cycle in ARMED
//   din_valid  : datapath sample valid (qualifies writes when valid_en=1)
//   bram_addr  : BRAM write address
//   bram_we    : BRAM write enable (aligned with bram_addr)
//   busy       : high in ARMED, DELAY and CAPTURE
//   done       : capture complete
//   status     : [ADDR_W:0] word count / next address, [31] wrapped flag
//   trig_ts    : (SNAP_CAPTURE_TS_EN only) cycle count at trigger acceptance
// -----------------------------------------------------------------------------
module snap_capture_ctrl
    import snap_capture_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DLY_W  = 16
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_word,
    input  logic              trig,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic [31:0]       status
`ifdef SNAP_CAPTURE_TS_EN
    ,
    output logic [31:0]       trig_ts
`endif
);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic              r_we, w_we_next;
    logic [31:0]       r_status, w_status_next;
    logic              r_wrapped, w_wrapped_next;
    logic [DLY_W-1:0]  r_dly, w_dly_next;

    logic              w_arm_re;
    logic              w_arm_accept;
    logic              w_q;
    logic              w_last;
    logic              w_wrap_now;
    logic [ADDR_W:0]   w_cnt;
    logic [31:0]       w_cap_status;
    logic              w_unused;

    snap_edge_det u_arm_edge (
        .i_clk  (user_clk),
        .i_rst  (user_rst),
        .i_d    (ctrl_word[ARM_BIT]),
        .o_rise (w_arm_re)
    );

    assign w_q    = ctrl_word[VALID_EN_BIT] ? din_valid : 1'b1;
    assign w_last = (r_addr == {ADDR_W{1'b1}});

    // r_addr counts completed writes; the write currently presented
    // (r_we=1) completes at the coming edge, so it is included here.
    assign w_cnt      = {1'b0, r_addr} + {{ADDR_W{1'b0}}, r_we};
    assign w_wrap_now = r_wrapped | (r_we & w_last);

    assign w_arm_accept = w_arm_re && ((r_state == IDLE) || (r_state == DONE));

    assign w_unused = ^ctrl_word[DLY_LSB-1:STOP_BIT+1];

    always_comb begin
        w_cap_status = '0;
        if (ctrl_word[CIRC_BIT]) begin
            w_cap_status[ADDR_W-1:0] = w_cnt[ADDR_W-1:0];
            w_cap_status[WRAP_BIT]   = w_wrap_now;
        end else begin
            w_cap_status[ADDR_W:0]   = w_cnt;
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_status  <= '0;
            r_wrapped <= 1'b0;
            r_dly     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_we      <= w_we_next;
            r_status  <= w_status_next;
            r_wrapped <= w_wrapped_next;
            r_dly     <= w_dly_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_we_next      = 1'b0;
        w_status_next  = r_status;
        w_wrapped_next = r_wrapped;
        w_dly_next     = r_dly;

        case (r_state)
            IDLE, DONE: begin
                // DONE re-arms in one step, clearing results on the way
                if (w_arm_re) begin
                    w_state_next   = ARMED;
                    w_addr_next    = '0;
                    w_status_next  = '0;
                    w_wrapped_next = 1'b0;
                end
            end

            ARMED: begin
                if (ctrl_word[STOP_BIT]) begin
                    w_state_next  = DONE;
                    w_status_next = '0;
                end else if (!ctrl_word[TRIG_EN_BIT] || trig) begin
                    w_state_next = DELAY;
                    w_dly_next   = ctrl_word[DLY_LSB +: DLY_W];
                end
            end

            DELAY: begin
                if (ctrl_word[STOP_BIT]) begin
                    w_state_next  = DONE;
                    w_status_next = '0;
                end else if (r_dly == '0) begin
                    // The final delay cycle doubles as the first capture
                    // slot so trigger-to-write latency is 2 + delay.
                    w_state_next = CAPTURE;
                    w_we_next    = w_q;
                end else if (w_q) begin
                    w_dly_next = r_dly - DLY_W'(1);
                end
            end

            CAPTURE: begin
                if (ctrl_word[STOP_BIT]) begin
                    w_state_next   = DONE;
                    w_status_next  = w_cap_status;
                    w_wrapped_next = w_wrap_now;
                end else if (r_we && w_last && !ctrl_word[CIRC_BIT]) begin
                    w_state_next  = DONE;
                    w_status_next = w_cap_status;
                end else begin
                    w_we_next = w_q;
                    if (r_we) begin
                        w_addr_next = r_addr + ADDR_W'(1);
                        if (w_last) begin
                            w_wrapped_next = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bram_addr = r_addr;
    assign bram_we   = r_we;
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);
    assign status    = r_status;

`ifdef SNAP_CAPTURE_TS_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_trig_ts;
    logic        w_ts_latch;

    assign w_ts_latch = (r_state == ARMED) && (w_state_next == DELAY);

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_ts_cnt  <= '0;
            r_trig_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_arm_accept) begin
                r_trig_ts <= '0;
            end else if (w_ts_latch) begin
                r_trig_ts <= r_ts_cnt;
            end
        end
    end

    assign trig_ts = r_trig_ts;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_arm_accept;
`endif

endmodule

// File: tb/tb_snap_capture_ctrl.sv
module tb_snap_capture_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic [31:0]   ctrl_word;
    logic          trig;
    logic          din_valid;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic [31:0]   status;
`ifdef SNAP_CAPTURE_TS_EN
    logic [31:0]   trig_ts;
    logic [31:0]   ref_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 user_clk = ~user_clk;

    snap_capture_ctrl #(.ADDR_W(AW), .DLY_W(16)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .ctrl_word (ctrl_word),
        .trig      (trig),
        .din_valid (din_valid),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .busy      (busy),
        .done      (done),
        .status    (status)
`ifdef SNAP_CAPTURE_TS_EN
        ,
        .trig_ts   (trig_ts)
`endif
    );

`ifdef SNAP_CAPTURE_TS_EN
    // Reference free-running cycle counter
    always @(posedge user_clk or posedge user_rst) begin
        if (user_rst) ref_cnt <= 32'd0;
        else          ref_cnt <= ref_cnt + 32'd1;
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ctrl(input bit arm, input bit te, input bit ve,
                                            input bit circ, input bit stop, input int dly);
        logic [31:0] w;
        w        = '0;
        w[0]     = arm;
        w[1]     = te;
        w[2]     = ve;
        w[3]     = circ;
        w[4]     = stop;
        w[31:16] = dly[15:0];
        return w;
    endfunction

    // One capture transaction checked against the rules:
    //  - delay counts qualified cycles after the trigger;
    //  - then every capture slot writes iff q, the k-th write at k mod DEPTH,
    //    visible one cycle after its slot;
    //  - stop or the DEPTH-th write (non-circular) ends the run.
    task automatic run_capture(input string name, input bit te, input int dly,
                               input bit ve, input int pat, input bit circ,
                               input int stop_at, input int trig_wait,
                               input bit rst_at7, output int slots);
        int          n;
        int          d;
        int          lat;
        bit          finished;
        bit          q;
        bit          dv;
        bit          stp;
        bit          fin;
        bit          exp_we;
        logic [31:0] exp_status;
        n        = 0;
        d        = dly;
        slots    = 0;
        lat      = -1;
        finished = 1'b0;
        trig      = 1'b0;
        din_valid = 1'b0;

        ctrl_word = mk_ctrl(0, te, ve, circ, 0, dly);
        step();
        // trigger coinciding with arm must not be taken
        ctrl_word = mk_ctrl(1, te, ve, circ, 0, dly);
        trig      = te;
        step();
        trig = 1'b0;
        checks++;
        if ({busy, done, bram_we} !== 3'b100) begin
            errors++;
            $display("FAIL %s_arm_flags busy/done/we=%b required 100", name, {busy, done, bram_we});
        end
        checks++;
        if (status !== 32'd0 || bram_addr !== '0) begin
            errors++;
            $display("FAIL %s_arm_clear status=%h addr=%0d required 0/0", name, status, bram_addr);
        end
`ifdef SNAP_CAPTURE_TS_EN
        checks++;
        if (trig_ts !== 32'd0) begin
            errors++;
            $display("FAIL %s_ts_clear trig_ts=%0d required 0", name, trig_ts);
        end
`endif
        if (te) begin
            for (int i = 0; i < trig_wait; i++) begin
                step();
                checks++;
                if (bram_we !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_armed_wait we=%b busy=%b required 0/1", name, bram_we, busy);
                end
            end
            trig = 1'b1;
        end
`ifdef SNAP_CAPTURE_TS_EN
        begin
            logic [31:0] exp_ts;
            exp_ts = ref_cnt;
            step();
            checks++;
            if (trig_ts !== exp_ts) begin
                errors++;
                $display("FAIL %s_trig_ts got=%0d required %0d", name, trig_ts, exp_ts);
            end
        end
`else
        step();
`endif
        trig = 1'b0;

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            case (pat)
                0:       dv = 1'b1;
                1:       dv = (cyc % 2 == 0);
                default: dv = 1'($urandom_range(0, 1));
            endcase
            q         = ve ? dv : 1'b1;
            stp       = (stop_at > 0) && (n == stop_at);
            fin       = stp || (!circ && n == DEPTH);
            din_valid = dv;
            ctrl_word = mk_ctrl(1, te, ve, circ, stp, dly);
            step();
            if (d == 0) slots++;
            if (fin) begin
                finished = 1'b1;
                if (circ) exp_status = (n % DEPTH) | ((n >= DEPTH) ? 32'h8000_0000 : 32'h0);
                else      exp_status = n;
                checks++;
                if ({busy, done, bram_we} !== 3'b010) begin
                    errors++;
                    $display("FAIL %s_done_flags busy/done/we=%b required 010", name, {busy, done, bram_we});
                end
                checks++;
                if (status !== exp_status) begin
                    errors++;
                    $display("FAIL %s_status got=%h required %h", name, status, exp_status);
                end
                if (pat == 0 && !ve) begin
                    // first write lands 2 + delay cycles after the trigger cycle
                    checks++;
                    if (lat !== dly + 1) begin
                        errors++;
                        $display("FAIL %s_latency got=%0d steps required %0d", name, lat, dly + 1);
                    end
                end
            end else begin
                if (d > 0) begin
                    if (q) d--;
                    exp_we = 1'b0;
                end else begin
                    exp_we = q;
                end
                if (bram_we === 1'b1 && lat < 0) lat = cyc + 1;
                checks++;
                if (bram_we !== exp_we) begin
                    errors++;
                    $display("FAIL %s_we cyc=%0d got=%b required %b", name, cyc, bram_we, exp_we);
                end
                if (exp_we) begin
                    checks++;
                    if (bram_addr !== AW'(n % DEPTH)) begin
                        errors++;
                        $display("FAIL %s_addr write=%0d got=%0d required %0d", name, n, bram_addr, n % DEPTH);
                    end
                    n++;
                    if (rst_at7 && n == 8) begin
                        user_rst = 1'b1;
                        #1;
                        checks++;
                        if ({busy, done, bram_we} !== 3'b000 || bram_addr !== '0 || status !== 32'd0) begin
                            errors++;
                            $display("FAIL %s_async_reset busy/done/we=%b addr=%0d status=%h required all 0",
                                     name, {busy, done, bram_we}, bram_addr, status);
                        end
                        ctrl_word = 32'd0;
                        din_valid = 1'b0;
                        #1;
                        user_rst = 1'b0;
                        $display("txn %s: reset asserted during write at addr 7", name);
                        return;
                    end
                end
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL %s_timeout capture did not reach DONE, writes=%0d", name, n);
        end
        $display("txn %s: te=%0d dly=%0d ve=%0d circ=%0d stop_at=%0d writes=%0d slots=%0d status=%h",
                 name, te, dly, ve, circ, stop_at, n, slots, status);
    endtask

    task automatic test_reset();
        user_rst  = 1'b1;
        ctrl_word = 32'd0;
        trig      = 1'b0;
        din_valid = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        checks++;
        if ({busy, done, bram_we} !== 3'b000 || bram_addr !== '0 || status !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold flags=%b addr=%0d status=%h required all 0", {busy, done, bram_we}, bram_addr, status);
        end
        user_rst = 1'b0;
        step();
        step();
        checks++;
        if ({busy, done, bram_we} !== 3'b000 || bram_addr !== '0 || status !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle flags=%b addr=%0d status=%h required all 0", {busy, done, bram_we}, bram_addr, status);
        end
        $display("txn reset: outputs idle");
    endtask

    task automatic test_rearm_hold();
        int s;
        ctrl_word = mk_ctrl(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({busy, done, bram_we} !== 3'b010) begin
                errors++;
                $display("FAIL rearm_hold cyc=%0d busy/done/we=%b required 010", i, {busy, done, bram_we});
            end
        end
        $display("txn rearm_hold: arm held high, no new capture");
        run_capture("rearm", 0, 0, 0, 0, 0, -1, 0, 0, s);
    endtask

    task automatic test_early_stop();
        // stop while ARMED
        ctrl_word = mk_ctrl(0, 1, 0, 0, 0, 0);
        step();
        ctrl_word = mk_ctrl(1, 1, 0, 0, 0, 0);
        step();
        step();
        ctrl_word = mk_ctrl(1, 1, 0, 0, 1, 0);
        step();
        checks++;
        if ({busy, done, bram_we} !== 3'b010 || status !== 32'd0) begin
            errors++;
            $display("FAIL stop_armed flags=%b status=%h required 010/0", {busy, done, bram_we}, status);
        end
        $display("txn stop_armed: status=%h", status);
        // stop while DELAY
        ctrl_word = mk_ctrl(0, 0, 0, 0, 0, 10);
        step();
        ctrl_word = mk_ctrl(1, 0, 0, 0, 0, 10);
        repeat (4) step();
        checks++;
        if (busy !== 1'b1 || bram_we !== 1'b0) begin
            errors++;
            $display("FAIL delay_busy busy=%b we=%b required 1/0", busy, bram_we);
        end
        ctrl_word = mk_ctrl(1, 0, 0, 0, 1, 10);
        step();
        checks++;
        if ({busy, done, bram_we} !== 3'b010 || status !== 32'd0) begin
            errors++;
            $display("FAIL stop_delay flags=%b status=%h required 010/0", {busy, done, bram_we}, status);
        end
        $display("txn stop_delay: status=%h", status);
    endtask

    task automatic test_random();
        int s;
        bit c;
        int st;
        for (int i = 0; i < 5; i++) begin
            c  = 1'($urandom_range(0, 1));
            st = c ? int'($urandom_range(5, 40)) : int'($urandom_range(3, 15));
            run_capture("random", 1, int'($urandom_range(0, 7)), 1, 2, c, st,
                        int'($urandom_range(0, 6)), 0, s);
        end
    endtask

    initial begin
        int s;
        test_reset();
        run_capture("basic", 0, 0, 0, 0, 0, -1, 0, 0, s);
        run_capture("trig_delay", 1, 3, 0, 0, 0, -1, 5, 0, s);
        run_capture("valid_toggle", 0, 0, 1, 1, 0, -1, 0, 0, s);
        checks++;
        if (s !== 32) begin
            errors++;
            $display("FAIL valid_toggle_cycles got=%0d required 32", s);
        end
        run_capture("circ", 0, 0, 0, 0, 1, 20, 0, 0, s);
        run_capture("stop_noncirc", 0, 2, 0, 0, 0, 6, 0, 0, s);
        run_capture("reset_mid", 0, 0, 0, 0, 0, -1, 0, 1, s);
        run_capture("after_reset", 1, 1, 0, 0, 0, -1, 2, 0, s);
        test_rearm_hold();
        test_early_stop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
